// File: rtl/video_sync_detector.sv
// ---------------------------------------------------------------------------
// video_sync_detector
//
// Receive-side timing recovery. Measures raw sync/DE timing on a pixel
// stream that is qualified by iPixelEn. It reports the measured horizontal
// and vertical total/active sizes and raises oLocked once LOCK_FRAMES
// consecutive frames measure identically. While locked it emits a
// one-cycle oPixelSync at the first active pixel of each frame.
//
// Sample qualification: iHsync/iVsync/iDe are only meaningful on cycles
// with iPixelEn high. Every edge detector compares the current qualified
// sample with the previous qualified sample. A cycle with iPixelEn low
// changes nothing, apart from oPixelSync dropping back to 0.
//
// Ports:
//   iClk        clock
//   iRst        asynchronous active-high reset
//   iPixelEn    sample strobe
//   iHsync      horizontal sync, active level HSYNC_POL
//   iVsync      vertical sync, active level VSYNC_POL
//   iDe         data enable (active pixel)
//   oPixelSync  one-cycle pulse at the first active pixel of a locked frame
//   oHtotal     measured pixels per line     (held from last lock)
//   oHactive    measured active pixels/line  (held from last lock)
//   oVtotal     measured lines per frame     (held from last lock)
//   oVactive    measured active lines/frame  (held from last lock)
//   oLocked     timing stable (high exactly while the FSM is LOCKED)
//   dbg_state   lock FSM state (0 SEARCH, 1 CHECK, 2 LOCKED)
// ---------------------------------------------------------------------------
module video_sync_detector #(
   parameter int   H_W         = 12,
   parameter int   V_W         = 11,
   parameter int   LOCK_FRAMES = 2,
   parameter logic HSYNC_POL   = 1'b1,
   parameter logic VSYNC_POL   = 1'b1
) (
   input  logic           iClk,
   input  logic           iRst,
   input  logic           iPixelEn,
   input  logic           iHsync,
   input  logic           iVsync,
   input  logic           iDe,
   output logic           oPixelSync,
   output logic [H_W-1:0] oHtotal,
   output logic [H_W-1:0] oHactive,
   output logic [V_W-1:0] oVtotal,
   output logic [V_W-1:0] oVactive,
   output logic           oLocked,
   output logic [1:0]     dbg_state
);

   localparam logic [H_W-1:0] H_MAX  = '1;
   localparam logic [V_W-1:0] V_MAX  = '1;
   localparam int             M_W    = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
   localparam logic [M_W-1:0] M_LOCK = M_W'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // ---------------- sample history and edge detection ----------------
   logic hs_now, vs_now;
   logic hs_prev, vs_prev, de_prev;
   logic hs_edge, vs_edge, de_rise, de_fall;

   assign hs_now  = (iHsync == HSYNC_POL);
   assign vs_now  = (iVsync == VSYNC_POL);
   assign hs_edge = iPixelEn &  hs_now & ~hs_prev;
   assign vs_edge = iPixelEn &  vs_now & ~vs_prev;
   assign de_rise = iPixelEn &  iDe    & ~de_prev;
   assign de_fall = iPixelEn & ~iDe    &  de_prev;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         hs_prev <= 1'b0;
         vs_prev <= 1'b0;
         de_prev <= 1'b0;
      end else if (iPixelEn) begin
         hs_prev <= hs_now;
         vs_prev <= vs_now;
         de_prev <= iDe;
      end
   end

   // ---------------- horizontal measurement ----------------
   // h_cnt restarts at 1 on the DE-rise pixel, so at the next DE rise it
   // holds the full line length and at DE fall the active length.
   logic [H_W-1:0] h_cnt, h_tot_meas, h_act_meas;
   logic           h_seen;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         h_cnt      <= '0;
         h_tot_meas <= '0;
         h_act_meas <= '0;
         h_seen     <= 1'b0;
      end else if (iPixelEn) begin
         if (de_rise) begin
            h_cnt  <= H_W'(1);
            h_seen <= 1'b1;
            // The first rise after reset follows a partial line.
            if (h_seen) h_tot_meas <= h_cnt;
         end else if (h_cnt != H_MAX) begin
            h_cnt <= h_cnt + H_W'(1);
         end
         if (de_fall) h_act_meas <= h_cnt;
      end
   end

   // ---------------- vertical measurement ----------------
   // Frame end is handled before the line events of the same sample, so a
   // coincident hsync/DE edge counts as the first line of the new frame.
   logic [V_W-1:0] v_cnt, v_act, v_cnt_nxt, v_act_nxt;
   logic           v_seen, capture, sync_loss;

   always_comb begin
      v_cnt_nxt = v_cnt;
      v_act_nxt = v_act;
      if (vs_edge) begin
         v_cnt_nxt = '0;
         v_act_nxt = '0;
      end
      if (hs_edge && (v_cnt_nxt != V_MAX)) v_cnt_nxt = v_cnt_nxt + V_W'(1);
      if (de_rise && (v_act_nxt != V_MAX)) v_act_nxt = v_act_nxt + V_W'(1);
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         v_cnt  <= '0;
         v_act  <= '0;
         v_seen <= 1'b0;
      end else begin
         v_cnt <= v_cnt_nxt;
         v_act <= v_act_nxt;
         if (vs_edge) v_seen <= 1'b1;
      end
   end

   // The first vsync after reset closes a partial frame: arm only.
   assign capture   = vs_edge & v_seen;
   assign sync_loss = (v_cnt_nxt == V_MAX);

   // ---------------- lock FSM ----------------
   state_t         state, state_nxt;
   logic [M_W-1:0] match_cnt, match_nxt, match_inc;
   logic [H_W-1:0] ref_ht, ref_ha, ref_ht_nxt, ref_ha_nxt;
   logic [V_W-1:0] ref_vt, ref_va, ref_vt_nxt, ref_va_nxt;
   logic           ref_load, same, armed, armed_nxt;
   logic           locked_nxt, out_load, pulse_nxt;

   // At a capture the frame measurement set is the current horizontal
   // registers plus the vertical counters about to be cleared.
   assign same = (h_tot_meas == ref_ht) && (h_act_meas == ref_ha) &&
                 (v_cnt == ref_vt) && (v_act == ref_va);
   assign match_inc = match_cnt + M_W'(1);

   // State register (also holds reference set and registered outputs).
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state      <= ST_SEARCH;
         match_cnt  <= '0;
         ref_ht     <= '0;
         ref_ha     <= '0;
         ref_vt     <= '0;
         ref_va     <= '0;
         armed      <= 1'b0;
         oLocked    <= 1'b0;
         oPixelSync <= 1'b0;
         oHtotal    <= '0;
         oHactive   <= '0;
         oVtotal    <= '0;
         oVactive   <= '0;
      end else begin
         state      <= state_nxt;
         match_cnt  <= match_nxt;
         ref_ht     <= ref_ht_nxt;
         ref_ha     <= ref_ha_nxt;
         ref_vt     <= ref_vt_nxt;
         ref_va     <= ref_va_nxt;
         armed      <= armed_nxt;
         oLocked    <= locked_nxt;
         oPixelSync <= pulse_nxt;
         if (out_load) begin
            oHtotal  <= ref_ht_nxt;
            oHactive <= ref_ha_nxt;
            oVtotal  <= ref_vt_nxt;
            oVactive <= ref_va_nxt;
         end
      end
   end

   // Next-state logic. Sync loss overrides any frame-end evaluation.
   always_comb begin
      state_nxt = state;
      match_nxt = match_cnt;
      ref_load  = 1'b0;
      if (sync_loss) begin
         state_nxt = ST_SEARCH;
         match_nxt = '0;
      end else if (capture) begin
         case (state)
            ST_SEARCH: begin
               ref_load  = 1'b1;
               match_nxt = M_W'(1);
               state_nxt = (LOCK_FRAMES == 1) ? ST_LOCKED : ST_CHECK;
            end
            ST_CHECK: begin
               if (same) begin
                  match_nxt = match_inc;
                  if (match_inc == M_LOCK) state_nxt = ST_LOCKED;
               end else begin
                  ref_load  = 1'b1;
                  match_nxt = M_W'(1);
               end
            end
            ST_LOCKED: begin
               if (!same) begin
                  state_nxt = ST_SEARCH;
                  match_nxt = '0;
               end
            end
            default: begin
               state_nxt = ST_SEARCH;
               match_nxt = '0;
            end
         endcase
      end
   end

   // Output logic.
   always_comb begin
      ref_ht_nxt = ref_load ? h_tot_meas : ref_ht;
      ref_ha_nxt = ref_load ? h_act_meas : ref_ha;
      ref_vt_nxt = ref_load ? v_cnt      : ref_vt;
      ref_va_nxt = ref_load ? v_act      : ref_va;
      locked_nxt = (state_nxt == ST_LOCKED);
      out_load   = (state_nxt == ST_LOCKED) && (state != ST_LOCKED);
      // A frame end arms; the first DE rise disarms. When both land on the
      // same sample the frame end counts first, so that rise still pulses.
      pulse_nxt  = de_rise && (armed || vs_edge) && (state_nxt == ST_LOCKED);
      armed_nxt  = armed;
      if (vs_edge) armed_nxt = 1'b1;
      if (de_rise) armed_nxt = 1'b0;
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_video_sync_detector.sv
// ---------------------------------------------------------------------------
// tb_video_sync_detector
//
// Two instances share one stimulus stream: dut0 uses active-high syncs,
// dut1 is built with active-low polarity and sees inverted syncs, so both
// must produce the same events. The stream is 32x24 total, 24x16 active,
// hsync at pixels 26..28, vsync on lines 20..21 starting at pixel 0, one
// pixel every second clock. Events are lock rise/fall (with the four size
// outputs) and pixel sync pulses, each tagged with its clock cycle.
// ---------------------------------------------------------------------------
module tb_video_sync_detector;

   localparam int         EW      = 68;
   localparam logic [1:0] K_NONE  = 2'd0;
   localparam logic [1:0] K_PULSE = 2'd1;
   localparam logic [1:0] K_RISE  = 2'd2;
   localparam logic [1:0] K_FALL  = 2'd3;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   logic pix_en, hsync, vsync, de_in;
   logic hsync_inv, vsync_inv;
   int unsigned cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   assign hsync_inv = ~hsync;
   assign vsync_inv = ~vsync;

   logic        ps0, lk0, ps1, lk1;
   logic [11:0] ht0, ha0, ht1, ha1;
   logic [10:0] vt0, va0, vt1, va1;
   logic [1:0]  st0, st1;

   video_sync_detector #(.H_W(12), .V_W(11), .LOCK_FRAMES(2),
                         .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_dut0 (
      .iClk(clk), .iRst(rst), .iPixelEn(pix_en), .iHsync(hsync),
      .iVsync(vsync), .iDe(de_in), .oPixelSync(ps0), .oHtotal(ht0),
      .oHactive(ha0), .oVtotal(vt0), .oVactive(va0), .oLocked(lk0),
      .dbg_state(st0)
   );

   video_sync_detector #(.H_W(12), .V_W(11), .LOCK_FRAMES(2),
                         .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_dut1 (
      .iClk(clk), .iRst(rst), .iPixelEn(pix_en), .iHsync(hsync_inv),
      .iVsync(vsync_inv), .iDe(de_in), .oPixelSync(ps1), .oHtotal(ht1),
      .oHactive(ha1), .oVtotal(vt1), .oVactive(va1), .oLocked(lk1),
      .dbg_state(st1)
   );

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q0[$];
   logic [EW-1:0] exp_q1[$];
   int checks;
   int errors;
   logic lk_prev0, lk_prev1;

   function automatic logic [EW-1:0] pack_ev(input logic [1:0] k, input int unsigned c,
                                             input logic [11:0] ht, input logic [11:0] ha,
                                             input logic [10:0] vt, input logic [10:0] va);
      return {k, 20'(c), ht, ha, vt, va};
   endfunction

   task automatic push_both(input logic [EW-1:0] ev);
      exp_q0.push_back(ev);
      exp_q1.push_back(ev);
   endtask

   task automatic compare_ev(input int d, input logic [EW-1:0] act);
      logic [EW-1:0] ev;
      int            qsize;
      checks++;
      qsize = (d == 0) ? exp_q0.size() : exp_q1.size();
      if (qsize == 0) begin
         errors++;
         $display("FAIL event_dut%0d: got kind %0d at cycle %0d, required no event",
                  d, act[67:66], act[65:46]);
      end else begin
         if (d == 0) ev = exp_q0.pop_front();
         else        ev = exp_q1.pop_front();
         if (act !== ev) begin
            errors++;
            $display("FAIL event_dut%0d: got kind %0d cyc %0d ht %0d ha %0d vt %0d va %0d, required kind %0d cyc %0d ht %0d ha %0d vt %0d va %0d",
                     d, act[67:66], act[65:46], act[45:34], act[33:22], act[21:11], act[10:0],
                     ev[67:66], ev[65:46], ev[45:34], ev[33:22], ev[21:11], ev[10:0]);
         end
      end
   endtask

   // Monitor: every lock transition and every pulse cycle is an event.
   initial begin
      lk_prev0 = 1'b0;
      lk_prev1 = 1'b0;
   end

   always @(negedge clk) begin
      if (lk0 !== lk_prev0)
         compare_ev(0, pack_ev(lk0 ? K_RISE : K_FALL, cyc, ht0, ha0, vt0, va0));
      if (ps0 === 1'b1)
         compare_ev(0, pack_ev(K_PULSE, cyc, 12'd0, 12'd0, 11'd0, 11'd0));
      if (lk1 !== lk_prev1)
         compare_ev(1, pack_ev(lk1 ? K_RISE : K_FALL, cyc, ht1, ha1, vt1, va1));
      if (ps1 === 1'b1)
         compare_ev(1, pack_ev(K_PULSE, cyc, 12'd0, 12'd0, 11'd0, 11'd0));
      lk_prev0 = lk0;
      lk_prev1 = lk1;
   end

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_psync0"},  32'(ps0), 32'd0);
      check_val({tag, "_locked0"}, 32'(lk0), 32'd0);
      check_val({tag, "_htot0"},   32'(ht0), 32'd0);
      check_val({tag, "_hact0"},   32'(ha0), 32'd0);
      check_val({tag, "_vtot0"},   32'(vt0), 32'd0);
      check_val({tag, "_vact0"},   32'(va0), 32'd0);
      check_val({tag, "_state0"},  32'(st0), 32'd0);
      check_val({tag, "_psync1"},  32'(ps1), 32'd0);
      check_val({tag, "_locked1"}, 32'(lk1), 32'd0);
      check_val({tag, "_htot1"},   32'(ht1), 32'd0);
      check_val({tag, "_hact1"},   32'(ha1), 32'd0);
      check_val({tag, "_vtot1"},   32'(vt1), 32'd0);
      check_val({tag, "_vact1"},   32'(va1), 32'd0);
      check_val({tag, "_state1"},  32'(st1), 32'd0);
   endtask

   // ---------------- drivers ----------------
   // One pixel: a qualified sample followed by one cycle of random junk
   // with pix_en low. An expected event for this sample is queued with the
   // cycle in which its registered result is visible.
   task automatic drive_pixel(input logic hs, input logic vs, input logic de,
                              input logic [1:0] k);
      @(negedge clk);
      pix_en = 1'b1;
      hsync  = hs;
      vsync  = vs;
      de_in  = de;
      if (k == K_PULSE)
         push_both(pack_ev(K_PULSE, cyc + 1, 12'd0, 12'd0, 11'd0, 11'd0));
      else if (k != K_NONE)
         push_both(pack_ev(k, cyc + 1, 12'd32, 12'd24, 11'd24, 11'd16));
      @(negedge clk);
      pix_en = 1'b0;
      hsync  = 1'($urandom_range(0, 1));
      vsync  = 1'($urandom_range(0, 1));
      de_in  = 1'($urandom_range(0, 1));
   endtask

   // end_kind is the lock event at the vsync edge (line 20, pixel 0);
   // pulse means a pixel sync is due at line 0, pixel 0.
   task automatic drive_frame(input int len, input int nlines,
                              input logic [1:0] end_kind, input logic pulse);
      logic [1:0] k;
      for (int y = 0; y < nlines; y++) begin
         for (int x = 0; x < len; x++) begin
            k = K_NONE;
            if (y == 0 && x == 0 && pulse) k = K_PULSE;
            if (y == 20 && x == 0) k = end_kind;
            drive_pixel(x >= 26 && x <= 28, y >= 20 && y <= 21, y < 16 && x < 24, k);
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      pix_en = 1'b0;
      hsync  = 1'b0;
      vsync  = 1'b0;
      de_in  = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      hsync = 1'b0;
      vsync = 1'b0;
      de_in = 1'b0;
      rst   = 1'b0;

      // Lock: arm, reference, match.
      drive_frame(32, 24, K_NONE, 1'b0);
      drive_frame(32, 24, K_NONE, 1'b0);
      drive_frame(32, 24, K_RISE, 1'b0);
      drive_frame(32, 24, K_NONE, 1'b1);
      drive_frame(32, 24, K_NONE, 1'b1);
      drive_frame(32, 24, K_NONE, 1'b1);

      // One frame of 33-pixel lines breaks lock; two good frames relock.
      drive_frame(33, 24, K_FALL, 1'b1);
      drive_frame(32, 24, K_NONE, 1'b0);
      drive_frame(32, 24, K_RISE, 1'b0);
      drive_frame(32, 24, K_NONE, 1'b1);

      // Asynchronous reset in the middle of a locked frame.
      drive_frame(32, 9, K_NONE, 1'b1);
      push_both(pack_ev(K_FALL, cyc + 1, 12'd0, 12'd0, 11'd0, 11'd0));
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      repeat (3) @(negedge clk);
      hsync = 1'b0;
      vsync = 1'b0;
      de_in = 1'b0;
      rst   = 1'b0;

      drive_frame(32, 24, K_NONE, 1'b0);
      drive_frame(32, 24, K_NONE, 1'b0);
      drive_frame(32, 24, K_RISE, 1'b0);
      drive_frame(32, 24, K_NONE, 1'b1);

      // Vsync removed: 4-pixel lines until the line counter saturates
      // (4 lines already counted after the last vsync, so line 2043).
      for (int n = 1; n <= 2045; n++)
         for (int x = 0; x < 4; x++)
            drive_pixel(x == 2, 1'b0, 1'b0, (n == 2043 && x == 2) ? K_FALL : K_NONE);

      // Active lines while unlocked and still armed: no pulse allowed.
      for (int n = 0; n < 3; n++)
         for (int x = 0; x < 8; x++)
            drive_pixel(x == 4, 1'b0, x < 2, K_NONE);

      repeat (20) @(negedge clk);
      check_val("leftover_events_dut0", 32'(exp_q0.size()), 32'd0);
      check_val("leftover_events_dut1", 32'(exp_q1.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
